// File: rtl/upload_reader.sv
// upload_reader: byte-wide upload reads served from a 16-bit toggle-handshake SDRAM port
// through a one-word cache. Define UPLOAD_READER_PREFETCH_EN to add next-word prefetch.
module upload_reader #(
    parameter int AW = 23
) (
    input  logic          clk_sys,
    input  logic          reset,
    input  logic          ioctl_upload,
    input  logic          ioctl_rd,
    input  logic [AW:0]   ioctl_addr,
    output logic [7:0]    ioctl_din,
    output logic          busy,
    output logic          port_req,
    input  logic          port_ack,
    output logic [AW-1:0] port_a,
    input  logic [15:0]   port_q,
    output logic [1:0]    dbg_state
);

`ifdef UPLOAD_READER_PREFETCH_EN
    typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, PFETCH = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1} state_t;
`endif

    // Port handshake: port_req toggles to issue one read; the read is complete in the
    // cycle port_ack differs from ack_seen, and port_q is valid in that same cycle.
    state_t        state;
    logic          ack_seen;
    logic          upload_d;
    logic          sel;
    logic [15:0]   buf_q;
    logic [AW-1:0] buf_a;
    logic          buf_v;
    logic          pend_v;
    logic [AW:0]   pend_addr;

    logic          upload_edge;
    logic          rd_now;
    logic          ack_evt;
    logic          outstanding;
    logic          req_v;
    logic [AW:0]   req_addr;
    logic [AW-1:0] req_w;
    logic          buf_hit;

    function automatic logic [7:0] byte_sel(input logic [15:0] w, input logic s);
        return s ? w[15:8] : w[7:0];
    endfunction

    assign upload_edge = ioctl_upload ^ upload_d;
    assign rd_now      = ioctl_rd && ioctl_upload;
    assign ack_evt     = port_ack != ack_seen;
    assign outstanding = ack_seen != port_req;
    assign req_v       = (state == IDLE) && ioctl_upload && (ioctl_rd || pend_v);
    assign req_addr    = ioctl_rd ? ioctl_addr : pend_addr;
    assign req_w       = req_addr[AW:1];
    assign buf_hit     = buf_v && (buf_a == req_w);
    assign dbg_state   = state;

`ifdef UPLOAD_READER_PREFETCH_EN
    logic [15:0]   pre_q;
    logic [AW-1:0] pre_a;
    logic          pre_v;
    logic          pf_want;
    logic          pf_drop;
    logic [AW-1:0] next_a;
    logic          pre_hit;
    logic          rd_buf_hit;

    assign next_a     = buf_a + {{(AW-1){1'b0}}, 1'b1};
    assign pre_hit    = pre_v && (pre_a == req_w);
    assign rd_buf_hit = buf_v && (buf_a == ioctl_addr[AW:1]);
`endif

    always_ff @(posedge clk_sys) begin
        upload_d <= ioctl_upload;
        if (reset) begin
            state     <= IDLE;
            ioctl_din <= 8'd0;
            busy      <= 1'b0;
            port_a    <= '0;
            // An in-flight request keeps its toggle so the late ack is absorbed, not replayed.
            port_req  <= outstanding ? port_req : port_ack;
            ack_seen  <= port_ack;
            sel       <= 1'b0;
            buf_q     <= 16'd0;
            buf_a     <= '0;
            buf_v     <= 1'b0;
            pend_v    <= 1'b0;
            pend_addr <= '0;
`ifdef UPLOAD_READER_PREFETCH_EN
            pre_q     <= 16'd0;
            pre_a     <= '0;
            pre_v     <= 1'b0;
            pf_want   <= 1'b0;
            pf_drop   <= 1'b0;
`endif
        end else begin
            if (ack_evt) ack_seen <= port_ack;
            case (state)
                IDLE: begin
                    if (req_v) begin
                        pend_v <= 1'b0;
                        if (buf_hit) begin
                            ioctl_din <= byte_sel(buf_q, req_addr[0]);
`ifdef UPLOAD_READER_PREFETCH_EN
                            if (req_addr[0]) pf_want <= 1'b1;
                        end else if (pre_hit) begin
                            ioctl_din <= byte_sel(pre_q, req_addr[0]);
                            buf_q     <= pre_q;
                            buf_a     <= pre_a;
                            buf_v     <= 1'b1;
                            pre_v     <= 1'b0;
                            pf_want   <= 1'b1;
`endif
                        end else if (!outstanding) begin
                            port_a   <= req_w;
                            port_req <= ~port_req;
                            busy     <= 1'b1;
                            sel      <= req_addr[0];
                            state    <= FETCH;
                        end else begin
                            // A stale request from before reset is still in flight.
                            pend_v    <= 1'b1;
                            pend_addr <= req_addr;
                        end
                    end
`ifdef UPLOAD_READER_PREFETCH_EN
                    else if (pf_want && buf_v && !outstanding) begin
                        pf_want <= 1'b0;
                        if (!(pre_v && pre_a == next_a)) begin
                            port_a   <= next_a;
                            port_req <= ~port_req;
                            pf_drop  <= 1'b0;
                            state    <= PFETCH;
                        end
                    end
`endif
                end
                FETCH: begin
                    if (rd_now) begin
                        pend_v    <= 1'b1;
                        pend_addr <= ioctl_addr;
                    end
                    if (ack_evt) begin
                        buf_q     <= port_q;
                        buf_a     <= port_a;
                        buf_v     <= 1'b1;
                        ioctl_din <= byte_sel(port_q, sel);
                        busy      <= 1'b0;
                        state     <= IDLE;
`ifdef UPLOAD_READER_PREFETCH_EN
                        pf_want   <= 1'b1;
`endif
                    end
                end
`ifdef UPLOAD_READER_PREFETCH_EN
                PFETCH: begin
                    if (rd_now) begin
                        if (rd_buf_hit) begin
                            ioctl_din <= byte_sel(buf_q, ioctl_addr[0]);
                            if (ioctl_addr[0]) pf_want <= 1'b1;
                        end else begin
                            pend_v    <= 1'b1;
                            pend_addr <= ioctl_addr;
                        end
                    end
                    if (ack_evt) begin
                        if (!pf_drop) begin
                            pre_q <= port_q;
                            pre_a <= port_a;
                            pre_v <= 1'b1;
                        end
                        state <= IDLE;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
            if (upload_edge) begin
                buf_v <= 1'b0;
`ifdef UPLOAD_READER_PREFETCH_EN
                pre_v   <= 1'b0;
                pf_want <= 1'b0;
                pf_drop <= 1'b1;
`endif
            end
            if (!ioctl_upload) pend_v <= 1'b0;
        end
    end

endmodule

// File: tb/tb_upload_reader.sv
// Bench for upload_reader: toggle-handshake SDRAM model, expected-byte queue checked by a
// monitor on every served read, plus directed checks of request traffic and reset behaviour.
module tb_upload_reader;
  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic        ioctl_upload = 1'b0;
  logic        ioctl_rd = 1'b0;
  logic [23:0] ioctl_addr = '0;
  logic [7:0]  ioctl_din;
  logic        busy;
  logic        port_req;
  logic        port_ack = 1'b0;
  logic [22:0] port_a;
  logic [15:0] port_q = '0;
  logic [1:0]  dbg_state;

  int n_tests = 0;
  int n_fail = 0;
  int toggles = 0;
  int ack_lat = 5;
  logic [7:0]  exp_q[$];
  logic [22:0] req_log[$];

  upload_reader #(.AW(23)) dut (
    .clk_sys(clk_sys), .reset(reset), .ioctl_upload(ioctl_upload), .ioctl_rd(ioctl_rd),
    .ioctl_addr(ioctl_addr), .ioctl_din(ioctl_din), .busy(busy), .port_req(port_req),
    .port_ack(port_ack), .port_a(port_a), .port_q(port_q), .dbg_state(dbg_state)
  );

  always #5 clk_sys = ~clk_sys;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  // Memory contents: word 0 is 0xBEEF, word a is {0x50+a[7:0], 0x30+a[7:0]} (8-bit wrap).
  function automatic logic [15:0] mem_word(input logic [22:0] a);
    logic [7:0] lo;
    lo = a[7:0];
    if (a == 23'd0) return 16'hBEEF;
    return {8'h50 + lo, 8'h30 + lo};
  endfunction

  // SDRAM model: acknowledges each request ack_lat cycles after the toggle.
  initial begin
    logic [22:0] a_lat;
    forever begin
      @(negedge clk_sys);
      if (port_req !== port_ack && !reset) begin
        a_lat = port_a;
        req_log.push_back(a_lat);
        toggles++;
        repeat (ack_lat - 1) @(negedge clk_sys);
        port_q = mem_word(a_lat);
        port_ack = ~port_ack;
      end
    end
  end

  // Monitor: a read is served either one cycle after an idle strobe or when busy falls.
  logic rd_s = 1'b0, rst_s = 1'b1, busy_pre = 1'b0;
  always @(posedge clk_sys) begin
    rd_s     <= ioctl_rd && ioctl_upload;
    rst_s    <= reset;
    busy_pre <= busy;
  end
  always @(negedge clk_sys) begin
    if (!rst_s && ((rd_s && !busy_pre && !busy) || (busy_pre && !busy))) begin
      if (exp_q.size() == 0) check("unexpected_output", {24'd0, ioctl_din}, 32'hFFFF_FFFF);
      else check("served_byte", {24'd0, ioctl_din}, {24'd0, exp_q.pop_front()});
    end
  end

  task automatic rd(input logic [23:0] a);
    @(negedge clk_sys);
    ioctl_rd = 1'b1;
    ioctl_addr = a;
    @(negedge clk_sys);
    ioctl_rd = 1'b0;
  endtask

  // Issue a missing read and confirm the request toggles one cycle after the strobe.
  task automatic rd_miss(input logic [23:0] a, input string name);
    logic req_before;
    req_before = port_req;
    rd(a);
    check({name, "_req_toggle"}, {31'd0, port_req}, {31'd0, ~req_before});
    check({name, "_busy_rise"}, {31'd0, busy}, 32'd1);
  endtask

  task automatic wait_done(input int n_toggles, input int budget, input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk_sys);
      if (toggles == n_toggles && !busy && port_req == port_ack && dbg_state == 2'd0) begin
        ok = 1'b1;
        break;
      end
    end
    check({name, "_done_in_budget"}, {31'd0, ok}, 32'd1);
  endtask

  task automatic check_req(input logic [22:0] a, input string name);
    if (req_log.size() == 0) check({name, "_req_logged"}, 32'd0, 32'd1);
    else check(name, {9'd0, req_log.pop_front()}, {9'd0, a});
  endtask

  initial begin
    repeat (3) @(negedge clk_sys);
    reset = 1'b0;
    check("reset_din", {24'd0, ioctl_din}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_req", {31'd0, port_req}, 32'd0);
    check("reset_port_a", {9'd0, port_a}, 32'd0);
    check("reset_state", {30'd0, dbg_state}, 32'd0);
    @(negedge clk_sys);
    ioctl_upload = 1'b1;
    repeat (2) @(negedge clk_sys);

`ifdef UPLOAD_READER_PREFETCH_EN
    begin
      logic [7:0] exp_b [8] = '{8'hEF, 8'hBE, 8'h31, 8'h51, 8'h32, 8'h52, 8'h33, 8'h53};
      ack_lat = 3;
      for (int i = 0; i < 8; i++) begin
        exp_q.push_back(exp_b[i]);
        rd(24'(i));
        if (i == 2 || i == 4 || i == 6) begin
          check($sformatf("pf_hit_busy_%0d", i), {31'd0, busy}, 32'd0);
          check($sformatf("pf_hit_din_%0d", i), {24'd0, ioctl_din}, {24'd0, exp_b[i]});
        end
        repeat (10) @(negedge clk_sys);
      end
      check("pf_toggles", toggles, 32'd5);
      for (int i = 0; i < 5; i++) check_req(23'(i), $sformatf("pf_port_a_%0d", i));
    end
`else
    // First miss: word 0, 0xBEEF after 5 cycles, low byte.
    exp_q.push_back(8'hEF);
    rd_miss(24'h000000, "miss0");
    wait_done(1, 20, "miss0");
    check("miss0_toggles", toggles, 32'd1);
    check_req(23'h0, "miss0_port_a");

    // Odd byte of the cached word: no new request.
    exp_q.push_back(8'hBE);
    rd(24'h000001);
    repeat (3) @(negedge clk_sys);
    check("hit1_din", {24'd0, ioctl_din}, 32'hBE);
    check("hit1_toggles", toggles, 32'd1);

    // Miss, then two strobes while busy: the last one (word 9) wins.
    exp_q.push_back(8'h32);
    exp_q.push_back(8'h39);
    rd_miss(24'h000004, "miss4");
    rd(24'h000010);
    rd(24'h000012);
    wait_done(3, 40, "pending");
    check_req(23'h2, "pend_port_a_first");
    check_req(23'h9, "pend_port_a_second");
    check("pend_din", {24'd0, ioctl_din}, 32'h39);

    // Upload edges invalidate the cache.
    @(negedge clk_sys);
    ioctl_upload = 1'b0;
    repeat (2) @(negedge clk_sys);
    ioctl_upload = 1'b1;
    repeat (2) @(negedge clk_sys);
    exp_q.push_back(8'hBE);
    rd_miss(24'h000001, "inval");
    wait_done(4, 20, "inval");
    check_req(23'h0, "inval_port_a");

    // Reset one cycle into a fetch; the late ack must be absorbed silently.
    ack_lat = 4;
    rd_miss(24'h000020, "rstmid");
    @(negedge clk_sys);
    reset = 1'b1;
    @(negedge clk_sys);
    reset = 1'b0;
    repeat (4) @(negedge clk_sys);
    check("rstmid_din", {24'd0, ioctl_din}, 32'd0);
    check("rstmid_busy", {31'd0, busy}, 32'd0);
    check("rstmid_state", {30'd0, dbg_state}, 32'd0);
    check("rstmid_ack_absorbed", {31'd0, port_ack}, {31'd0, port_req});
    check_req(23'h10, "rstmid_port_a");

    // Next read after the reset issues a clean request.
    exp_q.push_back(8'h60);
    rd_miss(24'h000021, "postrst");
    wait_done(6, 20, "postrst");
    check_req(23'h10, "postrst_port_a");

    // Top of the address space.
    exp_q.push_back(8'h2F);
    rd_miss(24'hFFFFFE, "top");
    wait_done(7, 20, "top");
    check_req(23'h7FFFFF, "top_port_a");

    // Strobes with upload low are ignored.
    @(negedge clk_sys);
    ioctl_upload = 1'b0;
    rd(24'h000002);
    repeat (3) @(negedge clk_sys);
    check("upload_low_toggles", toggles, 32'd7);
    check("upload_low_din", {24'd0, ioctl_din}, 32'h2F);
    check("upload_low_busy", {31'd0, busy}, 32'd0);
`endif

    repeat (3) @(negedge clk_sys);
    check("exp_q_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
